mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one synchronous single-port RAM between a CPU and a DMA requester.
// The CPU owns the RAM port by default. A DMA word costs two cycles: S_DMA
// issues the access, and S_DATA returns the read data while putting the CPU
// address back on the RAM. That way the CPU's read data is valid again in the
// next S_CPU cycle.
// After MAX_BURST back-to-back DMA words the CPU gets at least one unstalled
// cycle before the DMA requester is served again.
//
// Ports
//   clk, nreset                          clock, asynchronous active-low reset
//   cpu_address/cpu_data/cpu_wren        CPU request (in)
//   cpu_q                                RAM read data to CPU (out)
//   stall                                hold request to CPU (out)
//   dma_req                              DMA word request, held until dma_gnt (in)
//   dma_address/dma_data/dma_wren        DMA access, stable while dma_req (in)
//   dma_gnt                              DMA access issued this cycle (out)
//   dma_rvalid                           dma_q valid for the last granted read (out)
//   dma_q                                RAM read data to DMA (out)
//   ram_address/ram_data/ram_wren        RAM request (out)
//   ram_q                                RAM read data, one cycle after address (in)
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_wren,
  output logic [DATA_W-1:0] cpu_q,
  output logic              stall,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_data,
  input  logic              dma_wren,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_q,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    S_CPU  = 2'd0,
    S_DMA  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       wr_flag_q, wr_flag_d;
  logic       cpu_free_q, cpu_free_d;

  // Both requesters see the RAM read port directly.
  assign cpu_q = ram_q;
  assign dma_q = ram_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_CPU;
      burst_cnt_q <= 8'd0;
      wr_flag_q   <= 1'b0;
      cpu_free_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      wr_flag_q   <= wr_flag_d;
      cpu_free_q  <= cpu_free_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    wr_flag_d   = wr_flag_q;
    cpu_free_d  = cpu_free_q;
    ram_address = cpu_address;
    ram_data    = cpu_data;
    ram_wren    = cpu_wren;
    stall       = 1'b0;
    dma_gnt     = 1'b0;
    dma_rvalid  = 1'b0;

    unique case (state_q)
      S_CPU: begin
        // The free cycle after a capped burst lasts exactly one S_CPU cycle.
        cpu_free_d = 1'b0;
        if (dma_req && !cpu_free_q) begin
          state_d = S_DMA;
        end
      end

      S_DMA: begin
        ram_address = dma_address;
        ram_data    = dma_data;
        ram_wren    = dma_wren;
        stall       = 1'b1;
        dma_gnt     = 1'b1;
        wr_flag_d   = dma_wren;
        burst_cnt_d = burst_cnt_q + 8'd1;
        state_d     = S_DATA;
      end

      S_DATA: begin
        // Re-present the CPU address as a read so ram_q carries CPU data
        // when the CPU resumes. A held CPU write is re-applied in S_CPU.
        ram_address = cpu_address;
        ram_data    = cpu_data;
        ram_wren    = 1'b0;
        stall       = 1'b1;
        dma_rvalid  = !wr_flag_q;
        if (dma_req && (burst_cnt_q < MAX_BURST_C)) begin
          state_d = S_DMA;
        end else begin
          state_d     = S_CPU;
          burst_cnt_d = 8'd0;
          // Only a burst cut short by the cap with more work pending owes
          // the CPU a free cycle.
          cpu_free_d  = dma_req;
        end
      end

      default: begin
        state_d     = S_CPU;
        burst_cnt_d = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic [ADDR_W-1:0] cpu_address = '0;
  logic [DATA_W-1:0] cpu_data = '0;
  logic              cpu_wren = 1'b0;
  logic [DATA_W-1:0] cpu_q;
  logic              stall;
  logic              dma_req = 1'b0;
  logic [ADDR_W-1:0] dma_address = '0;
  logic [DATA_W-1:0] dma_data = '0;
  logic              dma_wren = 1'b0;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_q;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q = '0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .nreset(nreset),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_wren(cpu_wren),
    .cpu_q(cpu_q), .stall(stall),
    .dma_req(dma_req), .dma_address(dma_address), .dma_data(dma_data),
    .dma_wren(dma_wren), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_q(dma_q),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Known RAM contents loaded while preload is high.
  function automatic logic [31:0] init_val(input logic [15:0] a);
    if (a == 16'h0010) return 32'h0BAD_F00D;
    if (a == 16'h0200) return 32'h1234_5678;
    return 32'hA500_0000 | {16'h0000, a};
  endfunction

  // Synchronous RAM: write on edge, read data on ram_q the cycle after.
  logic        preload = 1'b1;
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(16'(i));
    end else begin
      if (ram_wren) mem[ram_address[9:0]] <= ram_data;
      ram_q <= mem[ram_address[9:0]];
    end
  end

  // Scoreboard of expected DMA read data and observed stall statistics.
  logic [31:0] sb[$];
  int runs[$];
  int gaps[$];
  int run = 0;
  int gap = 0;
  int gnt_cnt = 0;
  int rv_cnt = 0;
  logic prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!nreset || preload) begin
      run = 0;
      prev_stall = 1'b0;
    end else begin
      if (stall) begin
        if (!prev_stall) begin
          gaps.push_back(gap);
          gap = 0;
        end
        run++;
      end else begin
        if (run > 0) runs.push_back(run);
        run = 0;
        gap++;
      end
      prev_stall = stall;
      if (dma_gnt) begin
        gnt_cnt++;
        check("gnt_addr", 64'(ram_address), 64'(dma_address));
        if (!dma_wren) check("rd_no_wren", 64'(ram_wren), 64'd0);
      end
      if (dma_rvalid) begin
        rv_cnt++;
        if (sb.size() == 0) check("rvalid_unexp", 64'(dma_rvalid), 64'd0);
        else check("dma_q", 64'(dma_q), 64'(sb.pop_front()));
      end
    end
  end

  task automatic clear_stats();
    runs.delete();
    gaps.delete();
    run = 0;
    gap = 0;
    gnt_cnt = 0;
    rv_cnt = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue n DMA words; called and returns at posedge+1.
  task automatic dma_burst(input int n, input logic [15:0] base, input logic wr,
                           input logic [31:0] dbase);
    logic got;
    for (int i = 0; i < n; i++) begin
      dma_address = base + 16'(i);
      dma_data    = dbase + 32'(i);
      dma_wren    = wr;
      dma_req     = 1'b1;
      if (!wr) sb.push_back(init_val(base + 16'(i)));
      got = 1'b0;
      for (int c = 0; c < 64 && !got; c++) begin
        @(negedge clk);
        if (dma_gnt) got = 1'b1;
      end
      if (!got) begin
        check("gnt_timeout", 64'(dma_gnt), 64'd1);
        dma_req = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      check("gnt_wren", 64'(ram_wren), 64'(wr));
      @(posedge clk);
      #1;
    end
    dma_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic got;
    cpu_address = 16'h0077;
    wait_cycles(3);
    // Reset held: CPU owns the RAM, no stall, no DMA strobes.
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_gnt", 64'(dma_gnt), 64'd0);
    check("rst_rvalid", 64'(dma_rvalid), 64'd0);
    check("rst_ram_addr", 64'(ram_address), 64'h0077);
    preload = 1'b0;
    nreset  = 1'b1;

    // Idle CPU read.
    cpu_address = 16'h0010;
    @(negedge clk);
    check("idle_addr", 64'(ram_address), 64'h0010);
    check("idle_stall0", 64'(stall), 64'd0);
    wait_cycles(1);
    @(negedge clk);
    check("idle_cpu_q", 64'(cpu_q), 64'h0BAD_F00D);
    check("idle_stall1", 64'(stall), 64'd0);
    wait_cycles(1);

    // Single DMA write.
    clear_stats();
    dma_burst(1, 16'h0100, 1'b1, 32'hDEAD_BEEF);
    wait_cycles(3);
    check("wr_runs", 64'(runs.size()), 64'd1);
    check("wr_stall_len", 64'(runs[0]), 64'd2);
    check("wr_gnt_cnt", 64'(gnt_cnt), 64'd1);
    check("wr_rvalid_cnt", 64'(rv_cnt), 64'd0);
    check("wr_mem", 64'(mem[10'h100]), 64'hDEAD_BEEF);

    // Single DMA read, then CPU data is back on ram_q.
    clear_stats();
    dma_burst(1, 16'h0200, 1'b0, 32'h0);
    @(negedge clk);
    check("rd_rvalid", 64'(dma_rvalid), 64'd1);
    wait_cycles(1);
    @(negedge clk);
    check("rd_after_stall", 64'(stall), 64'd0);
    check("rd_after_cpu_q", 64'(cpu_q), 64'h0BAD_F00D);
    wait_cycles(2);
    check("rd_rvalid_cnt", 64'(rv_cnt), 64'd1);

    // Ten-word read burst split by the burst cap.
    clear_stats();
    dma_burst(10, 16'h0300, 1'b0, 32'h0);
    wait_cycles(4);
    check("burst_groups", 64'(runs.size()), 64'd3);
    check("burst_run0", 64'(runs[0]), 64'd8);
    check("burst_run1", 64'(runs[1]), 64'd8);
    check("burst_run2", 64'(runs[2]), 64'd4);
    check("burst_gap1", 64'(gaps[1] >= 1), 64'd1);
    check("burst_gap2", 64'(gaps[2] >= 1), 64'd1);
    check("burst_gnt_cnt", 64'(gnt_cnt), 64'd10);
    check("burst_rvalid_cnt", 64'(rv_cnt), 64'd10);

    // CPU store coincident with a DMA write request.
    cpu_address = 16'h0040;
    cpu_data    = 32'hC0FF_EE00;
    cpu_wren    = 1'b1;
    dma_burst(1, 16'h0140, 1'b1, 32'h55AA_55AA);
    check("store_at_grant", 64'(mem[10'h040]), 64'hC0FF_EE00);
    wait_cycles(2);
    cpu_wren    = 1'b0;
    cpu_address = 16'h0010;
    wait_cycles(2);
    check("store_cpu_mem", 64'(mem[10'h040]), 64'hC0FF_EE00);
    check("store_dma_mem", 64'(mem[10'h140]), 64'h55AA_55AA);

    // Reset in S_DMA of the second word of a burst.
    clear_stats();
    dma_address = 16'h0380;
    dma_data    = 32'h1111_1111;
    dma_wren    = 1'b1;
    dma_req     = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (dma_gnt) got = 1'b1;
    end
    @(posedge clk);
    #1;
    dma_address = 16'h0381;
    dma_data    = 32'h2222_2222;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (dma_gnt) got = 1'b1;
    end
    check("rst_mid_reached", 64'(got), 64'd1);
    #2;
    nreset = 1'b0;
    #1;
    check("rst_mid_stall", 64'(stall), 64'd0);
    check("rst_mid_gnt", 64'(dma_gnt), 64'd0);
    check("rst_mid_wren", 64'(ram_wren), 64'd0);
    dma_req = 1'b0;
    wait_cycles(1);
    nreset = 1'b1;
    wait_cycles(2);
    check("rst_word0_mem", 64'(mem[10'h380]), 64'h1111_1111);
    check("rst_word1_abandoned", 64'(mem[10'h381]), 64'hA500_0381);
    check("rst_idle_stall", 64'(stall), 64'd0);

    // A full capped burst after reset proves the word count restarted.
    clear_stats();
    dma_burst(4, 16'h03C0, 1'b1, 32'h7777_0000);
    wait_cycles(3);
    check("post_rst_groups", 64'(runs.size()), 64'd1);
    check("post_rst_run", 64'(runs[0]), 64'd8);
    check("post_rst_gnt_cnt", 64'(gnt_cnt), 64'd4);
    check("post_rst_mem", 64'(mem[10'h3C3]), 64'h7777_0003);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
